// File: rtl/param_deserializer_fsm_pkg.sv
// Shared types for the parametrised serial deserializer: FSM encoding and
// a constant-foldable ceil(log2) used to size the bit counter.
package param_deserializer_fsm_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/param_deserializer_fsm_if.sv
// Pin-side serial signals plus the word-side handshake of the deserializer.
// The deserializer is the "slave" end; the serial driver/consumer is "master".
interface param_deserializer_fsm_if
    import param_deserializer_fsm_pkg::*;
#(
    parameter int WIDTH = 14
);
    localparam int CW = clog2(WIDTH + 2);

    logic             ss;
    logic             sclk;
    logic             data_in;
    logic             ack;
    logic [WIDTH-1:0] data_out;
    logic             ready;
    logic             frame_err;
    logic             overrun;
    logic             state;
    logic [CW-1:0]    bit_count;

    modport master (
        output ss, sclk, data_in, ack,
        input  data_out, ready, frame_err, overrun, state, bit_count
    );

    modport slave (
        input  ss, sclk, data_in, ack,
        output data_out, ready, frame_err, overrun, state, bit_count
    );

endinterface

// File: rtl/param_deserializer_fsm_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous pin with registered
// single-cycle rise/fall pulses taken from the settled end of the chain.
module sync_edge_detect #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
            fall  <= ~chain[STAGES-1] & prev;
        end
    end

    assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/param_deserializer_fsm.sv
// Slave-select framed serial-to-parallel receiver: shifts exactly WIDTH bits
// per frame and hands the word over with a ready/ack handshake.
module param_deserializer_fsm
    import param_deserializer_fsm_pkg::*;
#(
    parameter int WIDTH       = 14,
    parameter bit MSB_FIRST   = 1'b1,
    parameter bit SAMPLE_EDGE = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input logic                    clock,
    input logic                    reset,
    param_deserializer_fsm_if.slave bus
);

    localparam int            CW       = clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

    logic ss_sync, ss_rise, ss_fall;
    logic sclk_sync, sclk_rise, sclk_fall;
    logic sample_evt, d;
    logic sync_unused;
    logic [SYNC_STAGES-1:0] d_sync;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_nx;
    logic [WIDTH-1:0] sr_q, sr_d, sr_nx;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ready_q, ready_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             complete;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss (
        .clock(clock), .reset(reset), .async_in(bus.ss),
        .sync_out(ss_sync), .rise(ss_rise), .fall(ss_fall)
    );

    // Idle level of sclk is the level just before the sampling edge.
    sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(SAMPLE_EDGE)) u_sclk (
        .clock(clock), .reset(reset), .async_in(bus.sclk),
        .sync_out(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
    );

    assign sync_unused = ss_sync ^ sclk_sync;
    assign sample_evt  = SAMPLE_EDGE ? sclk_fall : sclk_rise;
    assign d           = d_sync[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) d_sync <= '0;
        else       d_sync <= {d_sync[SYNC_STAGES-2:0], bus.data_in};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        dout_d   = dout_q;
        ready_d  = ready_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        complete = 1'b0;

        // A bit sampled in the same cycle as ss_rise still counts toward the frame.
        cnt_nx = cnt_q;
        sr_nx  = sr_q;
        if (sample_evt) begin
            cnt_nx = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
            if (MSB_FIRST) sr_nx = {sr_q[WIDTH-2:0], d};
            else           sr_nx = {d, sr_q[WIDTH-1:1]};
        end

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            SHIFT: begin
                if (ss_fall) begin
                    cnt_d = '0;
                    sr_d  = '0;
                end else if (ss_rise) begin
                    state_d = IDLE;
                    cnt_d   = cnt_nx;
                    sr_d    = sr_nx;
                    if (cnt_nx == CNT_FULL) complete = 1'b1;
                    else                    ferr_d   = 1'b1;
                end else begin
                    cnt_d = cnt_nx;
                    sr_d  = sr_nx;
                end
            end
        endcase

        if (complete) begin
            if (!ready_q || bus.ack) begin
                dout_d  = sr_nx;
                ready_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (bus.ack) begin
            ready_d = 1'b0;
        end
    end

    assign bus.data_out  = dout_q;
    assign bus.ready     = ready_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
    assign bus.state     = state_q;
    assign bus.bit_count = cnt_q;

endmodule

// File: doc/param_deserializer_fsm.md
Name: param_deserializer_fsm

Overview:
- Parametrised serial-to-parallel receiver for a slave-select framed serial link (SPI-slave style); successor to the fixed 14-bit deserializer.
- Synchronises external ss/sclk/data_in into the system clock domain and shifts in exactly WIDTH bits per frame, sampled on a selectable sclk edge, in a selectable bit order.
- Presents the completed word with a ready/ack handshake; flags frame-length errors and overruns.
- Sits between the external serial pins and the word-level consumer logic.

Parameters:
- WIDTH, 14, bits per frame and data_out width (2..64).
- MSB_FIRST, 1, 1: first received bit lands in data_out[WIDTH-1]; 0: first bit lands in data_out[0].
- SAMPLE_EDGE, 0, 0: sample data_in on sclk rising edge; 1: on falling edge.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (>=2).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ss  in  1  slave select, active-low frame envelope, asynchronous to clock.
- sclk  in  1  serial bit clock, asynchronous; at most clock/4 frequency.
- data_in  in  1  serial data, stable around the sampling sclk edge.
- ack  in  1  consumer accepts the held word.
- data_out  out  WIDTH  last completed word; held until replaced.
- ready  out  1  data_out holds an unacknowledged word.
- frame_err  out  1  one-cycle pulse: a frame ended with bit count != WIDTH.
- overrun  out  1  one-cycle pulse: a valid frame completed while ready=1 and ack=0.
- state  out  1  debug: current FSM state (0 IDLE, 1 SHIFT).
- bit_count  out  $clog2(WIDTH+2)  debug: bits received in the current frame.

Behaviour:
- Reset values: state=IDLE, bit_count=0, shift register=0, data_out=0, ready=0, frame_err=0, overrun=0; synchroniser flops reset to ss=1, sclk=SAMPLE_EDGE?1:0, data=0.
- Synchronisers: ss, sclk, and data_in each pass through SYNC_STAGES flops.
- Edge detect: compare last sync stage against one extra registered copy. Produces ss_fall, ss_rise, and sample_evt (sclk rise or fall per SAMPLE_EDGE).
- IDLE: sample_evt ignored. On ss_fall: clear bit_count and the shift register, go to SHIFT.
- SHIFT, on sample_evt:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], d}.
  - MSB_FIRST=0: sr <= {d, sr[WIDTH-1:1]}.
  - bit_count increments and saturates at WIDTH+1, which marks "too long".
- SHIFT, on ss_rise: go to IDLE.
  - bit_count == WIDTH: word completion.
  - Otherwise: frame_err pulses for 1 cycle; data_out and ready are unchanged.
- Same cycle as ss_rise, a sample_evt is counted before the length check.
- Word completion with ready=0, or with ack=1 in the same cycle: data_out <= sr and ready <= 1 on the next edge.
- Word completion with ready=1 and ack=0: overrun pulses; data_out keeps the old word; ready stays 1.
- ack with ready=1 and no completion: ready <= 0 next edge. ack with ready=0 has no effect.
- Latency: data_out/ready update on the (SYNC_STAGES+2)th clock edge after ss rises at the pin. frame_err and overrun pulse with the same timing.
- ss_fall while in SHIFT (glitch or a rise too short to be resolved): restart the frame, clear bit_count, no error.
- Reset asserted mid-frame: immediate return to reset values; the partial word is discarded.

Decomposition:
- Shared package: state encoding constants IDLE/SHIFT and a count-width function clog2.
- Natural sub-module: sync_edge_detect (parameter STAGES, RESET_VAL).
  - Ports: clock, reset, async_in, sync_out, rise, fall.
  - Instantiated for ss and sclk; a plain sync chain is used for data_in.

Test Plan (all with WIDTH=14 unless stated):
- Frame 0x2A5C, MSB first, rising-edge sampling, then ack after 5 clocks -> data_out=0x2A5C and ready=1 at edge SYNC_STAGES+2 after ss rise; ready=0 the edge after ack.
- Same bits with MSB_FIRST=0 -> data_out=0x0E95 (bit-reversed 0x2A5C).
- Frame of 13 bits, and separately 15 bits -> frame_err one-cycle pulse each time; ready stays 0; data_out stays 0.
- Frame 0x1111, no ack, then frame 0x3333 -> overrun pulses once; data_out stays 0x1111. Repeat with ack coincident with the second completion -> data_out=0x3333, ready stays 1, no overrun.
- reset asserted after 7 bits of a frame, then a full frame 0x0FF0 -> outputs return to zero immediately; the next frame yields 0x0FF0 with no frame_err.
- WIDTH=8, SAMPLE_EDGE=1, frame 0xA5 driven on falling edges -> data_out=0xA5; sclk glitches while ss=1 produce no state change.
